// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared divider/ALU definitions: width default, FSM encodings, op codes
package div_iter_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_SLT  = 4'h4,
        ALU_DIV  = 4'h8,
        ALU_DIVU = 4'h9
    } alu_op_t;

endpackage

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - request/response bundle between execute stage and divider
interface div_iter_if import div_iter_pkg::*; #(parameter int W = W_DEFAULT);

    logic           start;
    logic           sign;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           flush;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] result;

    modport master (
        output start, sign, dividend, divisor, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, sign, dividend, divisor, flush,
        output busy, valid, result
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division iteration (combinational)
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         qbit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem < divisor holds between steps, so the sign of the (W+1)-bit difference is the borrow
    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = ~diff[W];
    assign rem_next = qbit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - W-cycle restoring divider for DIV/DIVU, result as {hi=remainder, lo=quotient}
module div_iter import div_iter_pkg::*; #(
    parameter int W = W_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    div_iter_if.slave   bus
);

    localparam int CW = $clog2(W);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   dsr_q;
    logic           neg_q, neg_r, dz_q;
    logic [2*W-1:0] res_q;

    logic           last, accept;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W-1:0]   rem_nx;
    logic           qbit;
    logic [W-1:0]   q_final, q_signed, r_signed;

    div_step #(.W(W)) u_step (
        .rem      (rem_q),
        .bit_in   (quo_q[W-1]),
        .divisor  (dsr_q),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    assign last   = (cnt == CW'(W-1));
    assign accept = (state != S_CALC) && bus.start && !bus.flush;

    assign a_neg  = bus.sign & bus.dividend[W-1];
    assign b_neg  = bus.sign & bus.divisor[W-1];
    assign a_mag  = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag  = b_neg ? -bus.divisor  : bus.divisor;

    // Divide-by-zero leaves |dividend| in the remainder naturally; only the quotient is forced
    assign q_final  = {quo_q[W-2:0], qbit};
    assign q_signed = dz_q ? '1 : (neg_q ? -q_final : q_final);
    assign r_signed = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = bus.start ? S_CALC : S_IDLE;
            S_CALC:         if (last) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        if (bus.flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
            res_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= a_mag;
            dsr_q <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz_q  <= (bus.divisor == '0);
        end else if (state == S_CALC && !bus.flush) begin
            rem_q <= rem_nx;
            quo_q <= q_final;
            cnt   <= cnt + CW'(1);
            if (last) res_q <= {r_signed, q_signed};
        end
    end

    assign bus.busy   = (state == S_CALC);
    assign bus.valid  = (state == S_DONE);
    assign bus.result = res_q;

endmodule
